// File: rtl/decode_pkg.sv
// ============================================================================
// Module   : decode_pkg
// Purpose  : Shared definitions for the RV32 decode/issue stage: opcode
//            constants, ALU control codes, the control-signal bundle and
//            small decode helper functions.
// Ports    : none (package)
// Config   : DECODE_RV32M_EN (consumed by decode_issue_stage) enables the
//            M-extension codes ALU_MUL..ALU_REMU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package decode_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // funct7 values that select operation variants
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MULD = 7'b0000001;

  // ALU control codes
  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_SLL   = 5'd2;
  localparam logic [4:0] ALU_SLT   = 5'd3;
  localparam logic [4:0] ALU_SLTU  = 5'd4;
  localparam logic [4:0] ALU_XOR   = 5'd5;
  localparam logic [4:0] ALU_SRL   = 5'd6;
  localparam logic [4:0] ALU_SRA   = 5'd7;
  localparam logic [4:0] ALU_OR    = 5'd8;
  localparam logic [4:0] ALU_AND   = 5'd9;
  localparam logic [4:0] ALU_PASSB = 5'd10;
  localparam logic [4:0] ALU_MUL   = 5'd16;  // MUL..REMU follow as 16 + funct3

  typedef struct packed {
    logic alusrc;
    logic memtoreg;
    logic regwrite;
    logic memread;
    logic memwrite;
    logic branch;
    logic jump;
    logic jalr;
  } ctrl_t;

  // True when a 5-bit register index addresses an implemented register.
  function automatic logic idx_ok(input logic [4:0] idx, input int unsigned nregs);
    return (32'(idx) < nregs);
  endfunction

  function automatic logic [31:0] imm_i(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] ins);
    return {ins[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] ins);
    return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

endpackage

`default_nettype wire

// File: rtl/decode_regfile.sv
// ============================================================================
// Module   : decode_regfile
// Purpose  : Architectural register file with two combinational read ports,
//            one write port and same-cycle write-to-read bypass. x0 reads 0
//            and ignores writes; indices >= NREGS read 0 and are not written.
// Ports    : clk, reset (async, active-high)
//            rs1_i, rs2_i      - read indices
//            rdata1_o, rdata2_o- read data (bypassed)
//            we_i, rd_i, wdata_i - write port, lands on the rising edge
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_regfile
  import decode_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      rs1_i,
  input  logic [4:0]      rs2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o,
  input  logic            we_i,
  input  logic [4:0]      rd_i,
  input  logic [XLEN-1:0] wdata_i
);

  localparam int IDX_W = $clog2(NREGS);

  logic [XLEN-1:0] regs_q [NREGS];

  logic w_write;
  logic w_byp1;
  logic w_byp2;
  logic w_ok1;
  logic w_ok2;

  assign w_write = we_i && (rd_i != 5'd0) && idx_ok(rd_i, NREGS);
  assign w_ok1   = (rs1_i != 5'd0) && idx_ok(rs1_i, NREGS);
  assign w_ok2   = (rs2_i != 5'd0) && idx_ok(rs2_i, NREGS);
  assign w_byp1  = we_i && (rd_i == rs1_i);
  assign w_byp2  = we_i && (rd_i == rs2_i);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (w_write) begin
      regs_q[rd_i[IDX_W-1:0]] <= wdata_i;
    end
  end

  // Bypass only applies to in-range, non-zero sources, so x0 stays 0 even
  // when a write-back targets it in the same cycle.
  assign rdata1_o = !w_ok1 ? '0 : (w_byp1 ? wdata_i : regs_q[rs1_i[IDX_W-1:0]]);
  assign rdata2_o = !w_ok2 ? '0 : (w_byp2 ? wdata_i : regs_q[rs2_i[IDX_W-1:0]]);

endmodule

`default_nettype wire

// File: rtl/decode_issue_stage.sv
// ============================================================================
// Module   : decode_issue_stage
// Purpose  : Registered RV32 decode stage. Decodes one instruction per cycle
//            into operands, immediate and control, owns the register file,
//            inserts load-use bubbles and handshakes with fetch/execute.
// Ports    : clk, reset (async, active-high)
//            in_valid/in_ready/in_instr/in_pc/in_pc4 - from fetch
//            wb_we/wb_rd/wb_data                   - register write-back
//            flush                                 - kill slot and input
//            out_valid/out_ready + out_*           - ID/EX slot to execute
//            hazard_stall                          - load-use bubble this cycle
// Config   : DECODE_RV32M_EN - decode OP funct7=0000001 as the M extension
//            (aluctl 16..23); when undefined those encodings are illegal.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_issue_stage
  import decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ALUCTL_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [XLEN-1:0]     in_pc,
  input  logic [XLEN-1:0]     in_pc4,
  input  logic                wb_we,
  input  logic [4:0]          wb_rd,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_rd1,
  output logic [XLEN-1:0]     out_rd2,
  output logic [XLEN-1:0]     out_imm,
  output logic [XLEN-1:0]     out_pc,
  output logic [XLEN-1:0]     out_pc4,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [4:0]          out_rd,
  output logic [2:0]          out_funct3,
  output logic                out_alusrc,
  output logic                out_memtoreg,
  output logic                out_regwrite,
  output logic                out_memread,
  output logic                out_memwrite,
  output logic                out_branch,
  output logic                out_jump,
  output logic                out_jalr,
  output logic [ALUCTL_W-1:0] out_aluctl,
  output logic                out_illegal,
  output logic                hazard_stall
);

  // ---------------------------------------------------------------- fields
  logic [6:0] w_opc;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic [4:0] w_rd;
  logic [2:0] w_f3;
  logic [6:0] w_f7;

  assign w_opc = in_instr[6:0];
  assign w_rd  = in_instr[11:7];
  assign w_f3  = in_instr[14:12];
  assign w_rs1 = in_instr[19:15];
  assign w_rs2 = in_instr[24:20];
  assign w_f7  = in_instr[31:25];

  // ---------------------------------------------------------------- decode
  ctrl_t       w_ctrl;
  logic [4:0]  w_alu;
  logic [31:0] w_imm;
  logic        w_illegal;
  logic        w_use_rs1;
  logic        w_use_rs2;
  logic        w_use_rd;

  always_comb begin
    w_ctrl    = '0;
    w_alu     = ALU_ADD;
    w_imm     = '0;
    w_illegal = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_use_rd  = 1'b0;

    case (w_opc)
      OPC_LUI: begin
        w_ctrl.alusrc   = 1'b1;
        w_ctrl.regwrite = 1'b1;
        w_alu           = ALU_PASSB;
        w_imm           = imm_u(in_instr);
        w_use_rd        = 1'b1;
      end
      OPC_AUIPC: begin
        w_ctrl.alusrc   = 1'b1;
        w_ctrl.regwrite = 1'b1;
        w_imm           = imm_u(in_instr);
        w_use_rd        = 1'b1;
      end
      OPC_JAL: begin
        w_ctrl.jump     = 1'b1;
        w_ctrl.regwrite = 1'b1;
        w_imm           = imm_j(in_instr);
        w_use_rd        = 1'b1;
      end
      OPC_JALR: begin
        w_ctrl.alusrc   = 1'b1;
        w_ctrl.jump     = 1'b1;
        w_ctrl.jalr     = 1'b1;
        w_ctrl.regwrite = 1'b1;
        w_imm           = imm_i(in_instr);
        w_use_rs1       = 1'b1;
        w_use_rd        = 1'b1;
        w_illegal       = (w_f3 != 3'b000);
      end
      OPC_BRANCH: begin
        w_ctrl.branch = 1'b1;
        w_alu         = ALU_SUB;
        w_imm         = imm_b(in_instr);
        w_use_rs1     = 1'b1;
        w_use_rs2     = 1'b1;
        w_illegal     = (w_f3 == 3'b010) || (w_f3 == 3'b011);
      end
      OPC_LOAD: begin
        w_ctrl.alusrc   = 1'b1;
        w_ctrl.memread  = 1'b1;
        w_ctrl.memtoreg = 1'b1;
        w_ctrl.regwrite = 1'b1;
        w_imm           = imm_i(in_instr);
        w_use_rs1       = 1'b1;
        w_use_rd        = 1'b1;
        w_illegal       = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
      end
      OPC_STORE: begin
        w_ctrl.alusrc   = 1'b1;
        w_ctrl.memwrite = 1'b1;
        w_imm           = imm_s(in_instr);
        w_use_rs1       = 1'b1;
        w_use_rs2       = 1'b1;
        w_illegal       = (w_f3[2] == 1'b1) || (w_f3 == 3'b011);
      end
      OPC_OPIMM: begin
        w_ctrl.alusrc   = 1'b1;
        w_ctrl.regwrite = 1'b1;
        w_imm           = imm_i(in_instr);
        w_use_rs1       = 1'b1;
        w_use_rd        = 1'b1;
        case (w_f3)
          3'b000: w_alu = ALU_ADD;
          3'b010: w_alu = ALU_SLT;
          3'b011: w_alu = ALU_SLTU;
          3'b100: w_alu = ALU_XOR;
          3'b110: w_alu = ALU_OR;
          3'b111: w_alu = ALU_AND;
          3'b001: begin
            w_alu     = ALU_SLL;
            w_illegal = (w_f7 != F7_BASE);
          end
          default: begin  // 3'b101: SRLI / SRAI selected by funct7
            w_alu     = (w_f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            w_illegal = (w_f7 != F7_BASE) && (w_f7 != F7_ALT);
          end
        endcase
      end
      OPC_OP: begin
        w_ctrl.regwrite = 1'b1;
        w_use_rs1       = 1'b1;
        w_use_rs2       = 1'b1;
        w_use_rd        = 1'b1;
        case (w_f7)
          F7_BASE: begin
            case (w_f3)
              3'b000:  w_alu = ALU_ADD;
              3'b001:  w_alu = ALU_SLL;
              3'b010:  w_alu = ALU_SLT;
              3'b011:  w_alu = ALU_SLTU;
              3'b100:  w_alu = ALU_XOR;
              3'b101:  w_alu = ALU_SRL;
              3'b110:  w_alu = ALU_OR;
              default: w_alu = ALU_AND;
            endcase
          end
          F7_ALT: begin
            if (w_f3 == 3'b000) begin
              w_alu = ALU_SUB;
            end else if (w_f3 == 3'b101) begin
              w_alu = ALU_SRA;
            end else begin
              w_illegal = 1'b1;
            end
          end
`ifdef DECODE_RV32M_EN
          F7_MULD: w_alu = ALU_MUL | {2'b00, w_f3};
`endif
          default: w_illegal = 1'b1;
        endcase
      end
      default: w_illegal = 1'b1;
    endcase

    // Register indices beyond the implemented file (RV32E) are illegal, but
    // only for fields the format actually uses as register numbers.
    if ((w_use_rs1 && !idx_ok(w_rs1, NREGS)) ||
        (w_use_rs2 && !idx_ok(w_rs2, NREGS)) ||
        (w_use_rd  && !idx_ok(w_rd,  NREGS))) begin
      w_illegal = 1'b1;
    end

    if (w_illegal) begin
      w_ctrl = '0;
      w_alu  = ALU_ADD;
    end
  end

  // --------------------------------------------------------- register file
  logic [XLEN-1:0] w_rdata1;
  logic [XLEN-1:0] w_rdata2;

  decode_regfile #(
    .NREGS (NREGS),
    .XLEN  (XLEN)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .rs1_i    (w_rs1),
    .rs2_i    (w_rs2),
    .rdata1_o (w_rdata1),
    .rdata2_o (w_rdata2),
    .we_i     (wb_we),
    .rd_i     (wb_rd),
    .wdata_i  (wb_data)
  );

  // ------------------------------------------------------------ slot state
  logic                out_valid_q;
  logic                out_valid_d;
  logic [XLEN-1:0]     rd1_q, rd2_q, imm_q, pc_q, pc4_q;
  logic [4:0]          rs1_q, rs2_q, rd_q;
  logic [2:0]          funct3_q;
  ctrl_t               ctrl_q;
  logic [ALUCTL_W-1:0] aluctl_q;
  logic                illegal_q;

  // Load-use: the slot holds a load whose destination the incoming
  // instruction reads. rs2 is only a register for OP/STORE/BRANCH.
  logic w_hazard;
  logic w_load;

  assign w_hazard = out_valid_q && ctrl_q.memread && (rd_q != 5'd0) && in_valid &&
                    ((w_use_rs1 && (w_rs1 == rd_q)) || (w_use_rs2 && (w_rs2 == rd_q)));

  assign in_ready     = (!out_valid_q || out_ready) && !w_hazard && !flush;
  assign hazard_stall = w_hazard && !flush;
  assign w_load       = in_valid && in_ready;

  // Flush wins over load and hold; otherwise a consumed slot that is not
  // refilled (including the load-use case) drops to a bubble.
  always_comb begin
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (w_load) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      pc4_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      funct3_q    <= '0;
      ctrl_q      <= '0;
      aluctl_q    <= '0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (w_load) begin
        rd1_q     <= w_rdata1;
        rd2_q     <= w_rdata2;
        imm_q     <= XLEN'($signed(w_imm));
        pc_q      <= in_pc;
        pc4_q     <= in_pc4;
        rs1_q     <= w_rs1;
        rs2_q     <= w_rs2;
        rd_q      <= w_rd;
        funct3_q  <= w_f3;
        ctrl_q    <= w_ctrl;
        aluctl_q  <= ALUCTL_W'(w_alu);
        illegal_q <= w_illegal;
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  assign out_valid    = out_valid_q;
  assign out_rd1      = rd1_q;
  assign out_rd2      = rd2_q;
  assign out_imm      = imm_q;
  assign out_pc       = pc_q;
  assign out_pc4      = pc4_q;
  assign out_rs1      = rs1_q;
  assign out_rs2      = rs2_q;
  assign out_rd       = rd_q;
  assign out_funct3   = funct3_q;
  assign out_alusrc   = ctrl_q.alusrc;
  assign out_memtoreg = ctrl_q.memtoreg;
  assign out_regwrite = ctrl_q.regwrite;
  assign out_memread  = ctrl_q.memread;
  assign out_memwrite = ctrl_q.memwrite;
  assign out_branch   = ctrl_q.branch;
  assign out_jump     = ctrl_q.jump;
  assign out_jalr     = ctrl_q.jalr;
  assign out_aluctl   = aluctl_q;
  assign out_illegal  = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_decode_issue_stage.sv
// ============================================================================
// Module   : tb_decode_issue_stage
// Purpose  : Self-checking bench for decode_issue_stage: a decode vector
//            table plus directed sequences for bypass, load-use, backpressure,
//            flush and asynchronous reset. A second NREGS=16 instance checks
//            the RV32E index limit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instr, in_pc, in_pc4;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_ready;

  wire        in_ready, out_valid, hazard_stall, out_illegal;
  wire [31:0] out_rd1, out_rd2, out_imm, out_pc, out_pc4;
  wire [4:0]  out_rs1, out_rs2, out_rd, out_aluctl;
  wire [2:0]  out_funct3;
  wire        out_alusrc, out_memtoreg, out_regwrite, out_memread;
  wire        out_memwrite, out_branch, out_jump, out_jalr;

  wire        s_in_ready, s_out_valid, s_hazard_stall, s_out_illegal;
  wire [31:0] s_out_rd1, s_out_rd2, s_out_imm, s_out_pc, s_out_pc4;
  wire [4:0]  s_out_rs1, s_out_rs2, s_out_rd, s_out_aluctl;
  wire [2:0]  s_out_funct3;
  wire        s_out_alusrc, s_out_memtoreg, s_out_regwrite, s_out_memread;
  wire        s_out_memwrite, s_out_branch, s_out_jump, s_out_jalr;

  wire [7:0] ctrl = {out_alusrc, out_memtoreg, out_regwrite, out_memread,
                     out_memwrite, out_branch, out_jump, out_jalr};

  always #5 clk = ~clk;

  decode_issue_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_pc4(in_pc4),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd1(out_rd1), .out_rd2(out_rd2), .out_imm(out_imm),
    .out_pc(out_pc), .out_pc4(out_pc4),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_funct3(out_funct3),
    .out_alusrc(out_alusrc), .out_memtoreg(out_memtoreg), .out_regwrite(out_regwrite),
    .out_memread(out_memread), .out_memwrite(out_memwrite), .out_branch(out_branch),
    .out_jump(out_jump), .out_jalr(out_jalr), .out_aluctl(out_aluctl),
    .out_illegal(out_illegal), .hazard_stall(hazard_stall)
  );

  decode_issue_stage #(.NREGS(16)) dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_pc4(in_pc4),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_rd1(s_out_rd1), .out_rd2(s_out_rd2), .out_imm(s_out_imm),
    .out_pc(s_out_pc), .out_pc4(s_out_pc4),
    .out_rs1(s_out_rs1), .out_rs2(s_out_rs2), .out_rd(s_out_rd), .out_funct3(s_out_funct3),
    .out_alusrc(s_out_alusrc), .out_memtoreg(s_out_memtoreg), .out_regwrite(s_out_regwrite),
    .out_memread(s_out_memread), .out_memwrite(s_out_memwrite), .out_branch(s_out_branch),
    .out_jump(s_out_jump), .out_jalr(s_out_jalr), .out_aluctl(s_out_aluctl),
    .out_illegal(s_out_illegal), .hazard_stall(s_hazard_stall)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins);
    @(negedge clk);
    in_valid = v;
    in_instr = ins;
  endtask

  // ctrl bits: {alusrc, memtoreg, regwrite, memread, memwrite, branch, jump, jalr}
  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  alu;
    logic [7:0]  ctrl;
    logic        ill;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{"addi",  32'h00700293, 32'h00000007,  5'd5, 5'd0,  8'hA0, 1'b0};
    vecs[1]  = '{"lui",   32'h123450B7, 32'h12345000,  5'd1, 5'd10, 8'hA0, 1'b0};
    vecs[2]  = '{"sub",   32'h402081B3, 32'h00000000,  5'd3, 5'd1,  8'h20, 1'b0};
    vecs[3]  = '{"lw",    32'h0000A303, 32'h00000000,  5'd6, 5'd0,  8'hF0, 1'b0};
    vecs[4]  = '{"sw",    32'h0020A423, 32'h00000008,  5'd8, 5'd0,  8'h88, 1'b0};
    vecs[5]  = '{"beq",   32'hFE208EE3, 32'hFFFFFFFC, 5'd29, 5'd1,  8'h04, 1'b0};
    vecs[6]  = '{"jal",   32'h010000EF, 32'h00000010,  5'd1, 5'd0,  8'h22, 1'b0};
    vecs[7]  = '{"jalr",  32'h004280E7, 32'h00000004,  5'd1, 5'd0,  8'hA3, 1'b0};
    vecs[8]  = '{"srai",  32'h4031D113, 32'h00000403,  5'd2, 5'd7,  8'hA0, 1'b0};
    vecs[9]  = '{"badop", 32'h0000007F, 32'h00000000,  5'd0, 5'd0,  8'h00, 1'b1};
    vecs[10] = '{"badf7", 32'h40209033, 32'h00000000,  5'd0, 5'd0,  8'h00, 1'b1};
`ifdef DECODE_RV32M_EN
    vecs[11] = '{"mul",   32'h023100B3, 32'h00000000,  5'd1, 5'd16, 8'h20, 1'b0};
`else
    vecs[11] = '{"mul",   32'h023100B3, 32'h00000000,  5'd1, 5'd0,  8'h00, 1'b1};
`endif
    vecs[12] = '{"auipc", 32'h00001117, 32'h00001000,  5'd2, 5'd0,  8'hA0, 1'b0};
    vecs[13] = '{"sltiu", 32'hFFF13093, 32'hFFFFFFFF,  5'd1, 5'd4,  8'hA0, 1'b0};

    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; in_pc4 = '0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid",   32'(out_valid), 0);
    chk("rst_imm",     out_imm, 0);
    chk("rst_ctrl",    32'(ctrl), 0);
    chk("rst_illegal", 32'(out_illegal), 0);
    chk("rst_hazard",  32'(hazard_stall), 0);
    chk("rst_inready", 32'(in_ready), 1);
    @(negedge clk);
    reset = 1'b0;

    // RV32E: rd=x17 is beyond the 16-entry file
    drive(1'b1, 32'h002088B3);
    edge_sample();
    chk("e_valid",    32'(s_out_valid), 1);
    chk("e_illegal",  32'(s_out_illegal), 1);
    chk("e_regwrite", 32'(s_out_regwrite), 0);
    chk("full_legal", 32'(out_illegal), 0);

    // Decode table, one instruction per cycle back-to-back
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      in_pc    = 32'h100 + 32'(i) * 4;
      in_pc4   = in_pc + 4;
      edge_sample();
      chk({vecs[i].name, "_valid"},   32'(out_valid), 1);
      chk({vecs[i].name, "_imm"},     out_imm, vecs[i].imm);
      chk({vecs[i].name, "_rd"},      32'(out_rd), 32'(vecs[i].rd));
      chk({vecs[i].name, "_aluctl"},  32'(out_aluctl), 32'(vecs[i].alu));
      chk({vecs[i].name, "_ctrl"},    32'(ctrl), 32'(vecs[i].ctrl));
      chk({vecs[i].name, "_illegal"}, 32'(out_illegal), 32'(vecs[i].ill));
      chk({vecs[i].name, "_pc"},      out_pc, 32'h100 + 32'(i) * 4);
      chk({vecs[i].name, "_pc4"},     out_pc4, 32'h104 + 32'(i) * 4);
    end

    // Write-back bypass: WB x3=0x55 in the cycle ADD x4,x3,x3 is accepted
    @(negedge clk);
    in_instr = 32'h00318233; wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h55;
    edge_sample();
    chk("byp_rd1", out_rd1, 32'h55);
    chk("byp_rd2", out_rd2, 32'h55);
    @(negedge clk);
    in_instr = 32'h00018233; wb_we = 1'b0;  // ADD x4,x3,x0
    edge_sample();
    chk("rf_rd1", out_rd1, 32'h55);
    chk("rf_x0",  out_rd2, 0);
    @(negedge clk);
    in_instr = 32'h00300233; wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h99;  // ADD x4,x0,x3
    edge_sample();
    chk("x0_byp", out_rd1, 0);
    chk("x0_rs2", out_rd2, 32'h55);
    @(negedge clk);
    wb_we = 1'b0;

    // Load-use: LW x6,0(x1) then ADD x7,x6,x2
    drive(1'b1, 32'h0000A303);
    edge_sample();
    chk("lw_memread", 32'(out_memread), 1);
    drive(1'b1, 32'h002303B3);
    #1;
    chk("lu_stall",   32'(hazard_stall), 1);
    chk("lu_inready", 32'(in_ready), 0);
    edge_sample();
    chk("lu_bubble",  32'(out_valid), 0);
    chk("lu_clear",   32'(hazard_stall), 0);
    edge_sample();
    chk("lu_valid",   32'(out_valid), 1);
    chk("lu_rd",      32'(out_rd), 7);
    chk("lu_rs1",     32'(out_rs1), 6);
    // ADDI whose imm field aliases x6 in the rs2 slot must not stall
    drive(1'b1, 32'h0000A303);
    edge_sample();
    drive(1'b1, 32'h00608413);
    #1;
    chk("nolu_stall", 32'(hazard_stall), 0);
    edge_sample();
    chk("nolu_rd",    32'(out_rd), 8);
    chk("nolu_valid", 32'(out_valid), 1);

    // Backpressure: out_ready low for 3 cycles
    drive(1'b1, 32'h00700293);
    edge_sample();
    @(negedge clk);
    out_ready = 1'b0;
    in_instr  = 32'h00900493;
    for (int c = 0; c < 3; c++) begin
      edge_sample();
      chk("bp_valid",   32'(out_valid), 1);
      chk("bp_rd",      32'(out_rd), 5);
      chk("bp_imm",     out_imm, 7);
      chk("bp_inready", 32'(in_ready), 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    edge_sample();
    chk("bp_next_rd",  32'(out_rd), 9);
    chk("bp_next_imm", out_imm, 9);
    drive(1'b0, 32'h00700293);
    edge_sample();
    chk("bp_nodup", 32'(out_valid), 0);

    // Flush with a valid (stalled) slot and a valid incoming instruction
    drive(1'b1, 32'h00700293);
    edge_sample();
    @(negedge clk);
    in_instr = 32'h00900493; flush = 1'b1; out_ready = 1'b0;
    #1;
    chk("fl_inready", 32'(in_ready), 0);
    edge_sample();
    chk("fl_valid", 32'(out_valid), 0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    edge_sample();
    chk("fl_dropped", 32'(out_valid), 0);

    // Asynchronous reset mid-cycle, then first accept right after release
    drive(1'b1, 32'h00700293);
    edge_sample();
    chk("ar_pre", 32'(out_valid), 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_valid", 32'(out_valid), 0);
    chk("ar_rd",    32'(out_rd), 0);
    @(negedge clk);
    reset = 1'b0;
    in_instr = 32'h00318233;  // ADD x4,x3,x3: x3 was cleared by reset
    edge_sample();
    chk("ar_accept", 32'(out_valid), 1);
    chk("ar_rf",     out_rd1, 0);
    @(negedge clk);
    in_valid = 1'b0;
    edge_sample();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
